mem_miss_responder: RTL

MEM_MISS_RESPONDER -- requirements
Module: mem_miss_responder

---
 rtl/mem_miss_pkg.sv | 26 ++
 rtl/miss_req_arbiter.sv | 55 +++++
 rtl/mem_miss_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_miss_pkg.sv
// Shared types for the memory miss responder: FSM states, request-source
// encoding (priority order low to high index) and the default line size.
package mem_miss_pkg;

    localparam int LINE_WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        SRC_W1 = 3'd0,
        SRC_R1 = 3'd1,
        SRC_W2 = 3'd2,
        SRC_R2 = 3'd3,
        SRC_I  = 3'd4
    } src_e;

    function automatic logic src_is_read(input src_e s);
        return (s == SRC_R1) || (s == SRC_R2) || (s == SRC_I);
    endfunction

endpackage

// File: rtl/miss_req_arbiter.sv
// Edge-captures the five miss/store request levels into pending bits and
// picks the highest-priority pending source; abort kills the I-fetch request.
module miss_req_arbiter
    import mem_miss_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic writemiss1_i,
    input  logic readmiss1_i,
    input  logic writemiss2_i,
    input  logic readmiss2_i,
    input  logic ireadmiss_i,
    input  logic abort_i,
    input  logic grant_i,
    output logic sel_vld_o,
    output src_e sel_src_o
);

    logic [4:0] req, prev_q, pend_q, pend_d, elig, clr;

    // Bit index equals the source encoding, so index order is priority order.
    assign req = {ireadmiss_i, readmiss2_i, writemiss2_i, readmiss1_i, writemiss1_i};

    always_comb begin
        elig        = pend_q;
        elig[SRC_I] = pend_q[SRC_I] & ~abort_i;
        sel_vld_o   = 1'b0;
        sel_src_o   = SRC_W1;
        for (int k = 4; k >= 0; k--) begin
            if (elig[k]) begin
                sel_vld_o = 1'b1;
                sel_src_o = src_e'(3'(k));
            end
        end
    end

    always_comb begin
        clr = '0;
        if (grant_i) clr[sel_src_o] = 1'b1;
        // A rise while still pending is a no-op; a rise after the grant re-arms.
        pend_d = (pend_q & ~clr) | (req & ~prev_q);
        if (abort_i) pend_d[SRC_I] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= req;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/mem_miss_responder.sv
// Serves D-cache read misses, write-through stores and I-cache misses against
// a single main-memory port, assembling multi-beat fills into a cache line.
module mem_miss_responder
    import mem_miss_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         readmiss1,
    input  logic                         readmiss2,
    input  logic                         writemiss1,
    input  logic                         writemiss2,
    input  logic [ADDR_W-1:0]            addr1,
    input  logic [ADDR_W-1:0]            addr2,
    input  logic [DATA_W-1:0]            wdata1,
    input  logic [DATA_W-1:0]            wdata2,
    input  logic                         ireadmiss,
    input  logic [ADDR_W-1:0]            iaddr,
    input  logic                         abort,
    output logic                         ReadReady1,
    output logic                         ReadReady2,
    output logic                         WriteReady1,
    output logic                         WriteReady2,
    output logic                         iReadReady,
    output logic [LINE_WORDS*DATA_W-1:0] fill_line,
    output logic [ADDR_W-1:0]            fill_addr,
    output logic                         fill_we1,
    output logic                         fill_we2,
    output logic                         ifill_we,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ack
);

    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int OFF_W  = BEAT_W + 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    state_e                             state_q, state_d;
    src_e                               src_q, src_d, sel_src;
    logic                               sel_vld, grant;
    logic [ADDR_W-1:0]                  addr_q, addr_d, line_base;
    logic [DATA_W-1:0]                  wdata_q, wdata_d;
    logic [BEAT_W-1:0]                  beat_q, beat_d;
    logic                               squash_q, squash_d;
    logic [LINE_WORDS-1:0][DATA_W-1:0]  line_q, line_d;
    logic                               unused_addr_lsbs;

    assign grant            = (state_q == IDLE) && sel_vld;
    assign line_base        = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign fill_line        = line_q;
    assign unused_addr_lsbs = ^addr_q[1:0];

    miss_req_arbiter u_arb (
        .clk          (clk),
        .rst          (rst),
        .writemiss1_i (writemiss1),
        .readmiss1_i  (readmiss1),
        .writemiss2_i (writemiss2),
        .readmiss2_i  (readmiss2),
        .ireadmiss_i  (ireadmiss),
        .abort_i      (abort),
        .grant_i      (grant),
        .sel_vld_o    (sel_vld),
        .sel_src_o    (sel_src)
    );

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        beat_d      = beat_q;
        squash_d    = squash_q;
        line_d      = line_q;
        ReadReady1  = 1'b0;
        ReadReady2  = 1'b0;
        WriteReady1 = 1'b0;
        WriteReady2 = 1'b0;
        iReadReady  = 1'b0;
        fill_we1    = 1'b0;
        fill_we2    = 1'b0;
        ifill_we    = 1'b0;
        fill_addr   = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state_q)
            IDLE: begin
                beat_d   = '0;
                squash_d = 1'b0;
                if (sel_vld) begin
                    src_d = sel_src;
                    case (sel_src)
                        SRC_W1, SRC_R1: begin addr_d = addr1; wdata_d = wdata1; end
                        SRC_W2, SRC_R2: begin addr_d = addr2; wdata_d = wdata2; end
                        default:        begin addr_d = iaddr; wdata_d = '0;     end
                    endcase
                    state_d = src_is_read(sel_src) ? FILL : WRITE;
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wdata = wdata_q;
                if (mem_ack) state_d = RESP;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = line_base | ADDR_W'({beat_q, 2'b00});
                // A mispredict cannot stop the burst; it only hides the result.
                if (abort && (src_q == SRC_I)) squash_d = 1'b1;
                if (mem_ack) begin
                    line_d[beat_q] = mem_rdata;
                    beat_d         = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (src_is_read(src_q)) fill_addr = line_base;
                case (src_q)
                    SRC_W1: WriteReady1 = 1'b1;
                    SRC_W2: WriteReady2 = 1'b1;
                    SRC_R1: begin ReadReady1 = 1'b1; fill_we1 = 1'b1; end
                    SRC_R2: begin ReadReady2 = 1'b1; fill_we2 = 1'b1; end
                    default: begin
                        iReadReady = ~squash_q;
                        ifill_we   = ~squash_q;
                    end
                endcase
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            src_q    <= SRC_W1;
            addr_q   <= '0;
            wdata_q  <= '0;
            beat_q   <= '0;
            squash_q <= 1'b0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            beat_q   <= beat_d;
            squash_q <= squash_d;
            line_q   <= line_d;
        end
    end

endmodule
